// File: rtl/ctrl_pkg.sv
// ctrl_pkg -- shared encodings for the multicycle RISC-V control unit.
//   state_e     : FSM state encoding (also exported on the State debug port)
//   op_class_e  : opcode classes produced by op_class_dec
//   OP_*        : instr[6:0] opcode constants
//   IMM_*, ALUOP_*, SRCA_*, SRCB_*, RES_* : datapath select encodings
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXER   = 4'd6,
    S_EXEI   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_JAL    = 4'd10,
    S_TRAP   = 4'd11
  } state_e;

  typedef enum logic [2:0] {
    CLS_LOAD,
    CLS_STORE,
    CLS_RTYPE,
    CLS_IALU,
    CLS_BRANCH,
    CLS_JAL,
    CLS_OTHER
  } op_class_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] FUNCT3_BEQ = 3'b000;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUREG    = 2'b00;
  localparam logic [1:0] RES_RDATA     = 2'b01;
  localparam logic [1:0] RES_ALUDIRECT = 2'b10;

endpackage

// File: rtl/op_class_dec.sv
// op_class_dec -- combinational opcode decoder.
//   op       in  7  instr[6:0]
//   op_class out    instruction class used by the FSM in DECODE/MEMADR
//   imm_src  out 2  immediate-extender select (I for anything unlisted)
module op_class_dec
  import ctrl_pkg::*;
(
  input  logic [6:0] op,
  output op_class_e  op_class,
  output logic [1:0] imm_src
);

  always_comb begin
    op_class = CLS_OTHER;
    imm_src  = IMM_I;
    case (op)
      OP_LOAD:   op_class = CLS_LOAD;
      OP_IALU:   op_class = CLS_IALU;
      OP_RTYPE:  op_class = CLS_RTYPE;
      OP_STORE: begin
        op_class = CLS_STORE;
        imm_src  = IMM_S;
      end
      OP_BRANCH: begin
        op_class = CLS_BRANCH;
        imm_src  = IMM_B;
      end
      OP_JAL: begin
        op_class = CLS_JAL;
        imm_src  = IMM_J;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- Moore control FSM for a multicycle RV32 subset
// (lw, sw, R-type, I-ALU, beq, jal) with a ready/valid memory port.
//   clk, rst_n          clock, async active-low reset
//   op, funct3          instruction fields; Zero ALU flag; MemReady memory done
//   MemReq/MemWrite/AdrSrc                 memory request controls
//   IRWrite/PCWrite/RegWrite               register load strobes
//   ALUSrcA/ALUSrcB/ALUOp/ResultSrc/ImmSrc datapath selects
//   Illegal             sticky illegal-opcode flag; State debug state
// Optional feature: define ILLEGAL_OP_TRAP_EN to send unlisted opcodes to a
// TRAP state that sets Illegal until reset; otherwise they behave as nops.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic       Illegal,
  output logic [3:0] State
);

  state_e     state_q, state_d;
  op_class_e  op_class;
  logic [1:0] imm_src;
  logic       illegal;

  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;

  op_class_dec u_dec (
    .op       (op),
    .op_class (op_class),
    .imm_src  (imm_src)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_q, illegal_d;

  always_comb begin
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = '0;
    alu_src_b  = '0;
    alu_op     = '0;
    result_src = '0;

    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        adr_src    = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUDIRECT;
        if (MemReady) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
        case (op_class)
          CLS_LOAD, CLS_STORE: state_d = S_MEMADR;
          CLS_RTYPE:           state_d = S_EXER;
          CLS_IALU:            state_d = S_EXEI;
          CLS_BRANCH:          state_d = S_BEQ;
          CLS_JAL:             state_d = S_JAL;
`ifdef ILLEGAL_OP_TRAP_EN
          default:             state_d = S_TRAP;
`else
          default:             state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
        if (op_class == CLS_STORE) state_d = S_MEMWR;
        else if (op_class == CLS_LOAD) state_d = S_MEMRD;
        else state_d = S_FETCH;
      end
      S_MEMRD: begin
        mem_req    = 1'b1;
        adr_src    = 1'b1;
        result_src = RES_ALUREG;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_RDATA;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req    = 1'b1;
        mem_write  = 1'b1;
        adr_src    = 1'b1;
        result_src = RES_ALUREG;
        if (MemReady) state_d = S_FETCH;
      end
      S_EXER: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXEI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUREG;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUREG;
        pc_write   = Zero & (funct3 == FUNCT3_BEQ);
        state_d    = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUREG;
        pc_write   = 1'b1;
        state_d    = S_ALUWB;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // FETCH is the reset state but drives MemReq=1, so every output is also
  // qualified by rst_n to read 0 for the whole time reset is held.
  always_comb begin
    MemReq    = mem_req   & rst_n;
    MemWrite  = mem_write & rst_n;
    AdrSrc    = adr_src   & rst_n;
    IRWrite   = ir_write  & rst_n;
    PCWrite   = pc_write  & rst_n;
    RegWrite  = reg_write & rst_n;
    ALUSrcA   = rst_n ? alu_src_a  : '0;
    ALUSrcB   = rst_n ? alu_src_b  : '0;
    ALUOp     = rst_n ? alu_op     : '0;
    ResultSrc = rst_n ? result_src : '0;
    ImmSrc    = (rst_n && state_q != S_TRAP) ? imm_src : '0;
    Illegal   = illegal & rst_n;
    State     = state_q;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       Zero;
  logic       MemReady;
  logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc;
  logic       Illegal;
  logic [3:0] State;

  int checks   = 0;
  int failures = 0;

  // Packed view: MemReq MemWrite AdrSrc IRWrite PCWrite RegWrite |
  //              ALUSrcA ALUSrcB ALUOp ResultSrc ImmSrc | Illegal
  logic [16:0] ov;
  assign ov = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc, Illegal};

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .funct3    (funct3),
    .Zero      (Zero),
    .MemReady  (MemReady),
    .MemReq    (MemReq),
    .MemWrite  (MemWrite),
    .AdrSrc    (AdrSrc),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .RegWrite  (RegWrite),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .ResultSrc (ResultSrc),
    .ImmSrc    (ImmSrc),
    .Illegal   (Illegal),
    .State     (State)
  );

  task automatic test_reset();
    rst_n = 1'b0; op = 7'b0100011; funct3 = 3'b000; Zero = 1'b1; MemReady = 1'b1;
    #2;
    checks++;
    if (ov !== 17'b0) begin failures++; $display("FAIL reset_outputs got=%b exp=%b", ov, 17'b0); end
    checks++;
    if (State !== 4'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", State); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ov !== 17'b0) begin failures++; $display("FAIL reset_held got=%b exp=%b", ov, 17'b0); end
    @(negedge clk);
    rst_n = 1'b1; MemReady = 1'b0;
    #1;
    checks++;
    if (State !== 4'd0) begin failures++; $display("FAIL release_state got=%0d exp=0", State); end
    checks++;
    if (ov !== 17'b1_0_0_0_0_0_00_10_00_10_01_0) begin
      failures++; $display("FAIL release_fetch got=%b exp=%b", ov, 17'b1_0_0_0_0_0_00_10_00_10_01_0);
    end
  endtask

  task automatic test_alu_ops();
    logic [6:0]  ops [3];
    logic [3:0]  st  [3][4];
    logic [16:0] ev  [3][4];
    ops = '{7'b0110011, 7'b0010011, 7'b1101111};
    st  = '{'{4'd0, 4'd1, 4'd6, 4'd8}, '{4'd0, 4'd1, 4'd7, 4'd8}, '{4'd0, 4'd1, 4'd10, 4'd8}};
    ev  = '{'{17'b1_0_0_1_1_0_00_10_00_10_00_0, 17'b0_0_0_0_0_0_01_01_00_00_00_0,
              17'b0_0_0_0_0_0_10_00_10_00_00_0, 17'b0_0_0_0_0_1_00_00_00_00_00_0},
            '{17'b1_0_0_1_1_0_00_10_00_10_00_0, 17'b0_0_0_0_0_0_01_01_00_00_00_0,
              17'b0_0_0_0_0_0_10_01_10_00_00_0, 17'b0_0_0_0_0_1_00_00_00_00_00_0},
            '{17'b1_0_0_1_1_0_00_10_00_10_11_0, 17'b0_0_0_0_0_0_01_01_00_00_11_0,
              17'b0_0_0_0_1_0_01_10_00_00_11_0, 17'b0_0_0_0_0_1_00_00_00_00_11_0}};
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        op = ops[s]; MemReady = 1'b1;
        #1;
        checks++;
        if (State !== st[s][c]) begin
          failures++; $display("FAIL alu_state op=%b cyc=%0d got=%0d exp=%0d", ops[s], c, State, st[s][c]);
        end
        checks++;
        if (ov !== ev[s][c]) begin
          failures++; $display("FAIL alu_outputs op=%b cyc=%0d got=%b exp=%b", ops[s], c, ov, ev[s][c]);
        end
      end
      @(negedge clk);
      MemReady = 1'b0;
      #1;
      checks++;
      if (State !== 4'd0) begin failures++; $display("FAIL alu_return op=%b got=%0d exp=0", ops[s], State); end
    end
  endtask

  task automatic test_memory();
    logic        rdy_l [8];
    logic [3:0]  st_l  [8];
    logic [16:0] ev_l  [8];
    logic        rdy_s [5];
    logic [3:0]  st_s  [5];
    logic [16:0] ev_s  [5];
    rdy_l = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    st_l  = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
    ev_l  = '{17'b1_0_0_0_0_0_00_10_00_10_00_0, 17'b1_0_0_1_1_0_00_10_00_10_00_0,
              17'b0_0_0_0_0_0_01_01_00_00_00_0, 17'b0_0_0_0_0_0_10_01_00_00_00_0,
              17'b1_0_1_0_0_0_00_00_00_00_00_0, 17'b1_0_1_0_0_0_00_00_00_00_00_0,
              17'b1_0_1_0_0_0_00_00_00_00_00_0, 17'b0_0_0_0_0_1_00_00_00_01_00_0};
    rdy_s = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    st_s  = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
    ev_s  = '{17'b1_0_0_1_1_0_00_10_00_10_01_0, 17'b0_0_0_0_0_0_01_01_00_00_01_0,
              17'b0_0_0_0_0_0_10_01_00_00_01_0, 17'b1_1_1_0_0_0_00_00_00_00_01_0,
              17'b1_1_1_0_0_0_00_00_00_00_01_0};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      op = 7'b0000011; MemReady = rdy_l[c];
      #1;
      checks++;
      if (State !== st_l[c]) begin failures++; $display("FAIL lw_state cyc=%0d got=%0d exp=%0d", c, State, st_l[c]); end
      checks++;
      if (ov !== ev_l[c]) begin failures++; $display("FAIL lw_outputs cyc=%0d got=%b exp=%b", c, ov, ev_l[c]); end
    end
    @(negedge clk);
    MemReady = 1'b0;
    #1;
    checks++;
    if (State !== 4'd0) begin failures++; $display("FAIL lw_return got=%0d exp=0", State); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      op = 7'b0100011; MemReady = rdy_s[c];
      #1;
      checks++;
      if (State !== st_s[c]) begin failures++; $display("FAIL sw_state cyc=%0d got=%0d exp=%0d", c, State, st_s[c]); end
      checks++;
      if (ov !== ev_s[c]) begin failures++; $display("FAIL sw_outputs cyc=%0d got=%b exp=%b", c, ov, ev_s[c]); end
    end
    @(negedge clk);
    MemReady = 1'b0;
    #1;
    checks++;
    if (State !== 4'd0) begin failures++; $display("FAIL sw_return got=%0d exp=0", State); end
  endtask

  task automatic test_branch();
    logic        zs  [3];
    logic [2:0]  f3s [3];
    logic [3:0]  st  [3];
    logic [16:0] ev  [3][3];
    zs  = '{1'b1, 1'b0, 1'b1};
    f3s = '{3'b000, 3'b000, 3'b001};
    st  = '{4'd0, 4'd1, 4'd9};
    ev  = '{'{17'b1_0_0_1_1_0_00_10_00_10_10_0, 17'b0_0_0_0_0_0_01_01_00_00_10_0,
              17'b0_0_0_0_1_0_10_00_01_00_10_0},
            '{17'b1_0_0_1_1_0_00_10_00_10_10_0, 17'b0_0_0_0_0_0_01_01_00_00_10_0,
              17'b0_0_0_0_0_0_10_00_01_00_10_0},
            '{17'b1_0_0_1_1_0_00_10_00_10_10_0, 17'b0_0_0_0_0_0_01_01_00_00_10_0,
              17'b0_0_0_0_0_0_10_00_01_00_10_0}};
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        op = 7'b1100011; MemReady = 1'b1; Zero = zs[s]; funct3 = f3s[s];
        #1;
        checks++;
        if (State !== st[c]) begin
          failures++; $display("FAIL beq_state case=%0d cyc=%0d got=%0d exp=%0d", s, c, State, st[c]);
        end
        checks++;
        if (ov !== ev[s][c]) begin
          failures++; $display("FAIL beq_outputs case=%0d cyc=%0d got=%b exp=%b", s, c, ov, ev[s][c]);
        end
      end
      @(negedge clk);
      MemReady = 1'b0;
      #1;
      checks++;
      if (State !== 4'd0) begin failures++; $display("FAIL beq_return case=%0d got=%0d exp=0", s, State); end
    end
    Zero = 1'b0; funct3 = 3'b000;
  endtask

  task automatic test_illegal();
    @(negedge clk);
    op = 7'b0000000; MemReady = 1'b1;
    #1;
    checks++;
    if (ov !== 17'b1_0_0_1_1_0_00_10_00_10_00_0) begin
      failures++; $display("FAIL ill_fetch got=%b exp=%b", ov, 17'b1_0_0_1_1_0_00_10_00_10_00_0);
    end
    @(negedge clk);
    #1;
    checks++;
    if (ov !== 17'b0_0_0_0_0_0_01_01_00_00_00_0 || State !== 4'd1) begin
      failures++; $display("FAIL ill_decode got=%b/%0d exp=%b/1", ov, State, 17'b0_0_0_0_0_0_01_01_00_00_00_0);
    end
`ifdef ILLEGAL_OP_TRAP_EN
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (State !== 4'd11) begin failures++; $display("FAIL trap_state cyc=%0d got=%0d exp=11", c, State); end
      checks++;
      if (ov !== 17'd1) begin failures++; $display("FAIL trap_outputs cyc=%0d got=%b exp=%b", c, ov, 17'd1); end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov !== 17'b0 || State !== 4'd0) begin
      failures++; $display("FAIL trap_reset got=%b/%0d exp=%b/0", ov, State, 17'b0);
    end
    @(negedge clk);
    rst_n = 1'b1; MemReady = 1'b0;
    #1;
    checks++;
    if (Illegal !== 1'b0 || State !== 4'd0) begin
      failures++; $display("FAIL trap_release got=%b/%0d exp=0/0", Illegal, State);
    end
`else
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      MemReady = 1'b0;
      #1;
      checks++;
      if (State !== 4'd0) begin failures++; $display("FAIL nop_state cyc=%0d got=%0d exp=0", c, State); end
      checks++;
      if (Illegal !== 1'b0) begin failures++; $display("FAIL nop_illegal cyc=%0d got=%b exp=0", c, Illegal); end
    end
`endif
  endtask

  task automatic test_reset_mid_write();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      op = 7'b0100011; MemReady = 1'b1;
    end
    @(negedge clk);
    MemReady = 1'b0;
    #1;
    checks++;
    if (State !== 4'd5 || MemReq !== 1'b1 || MemWrite !== 1'b1) begin
      failures++; $display("FAIL midwr_pre got=%0d/%b%b exp=5/11", State, MemReq, MemWrite);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (MemReq !== 1'b0 || MemWrite !== 1'b0) begin
      failures++; $display("FAIL midwr_drop got=%b%b exp=00", MemReq, MemWrite);
    end
    checks++;
    if (ov !== 17'b0 || State !== 4'd0) begin
      failures++; $display("FAIL midwr_zero got=%b/%0d exp=%b/0", ov, State, 17'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (State !== 4'd0 || ov !== 17'b1_0_0_0_0_0_00_10_00_10_01_0) begin
      failures++; $display("FAIL midwr_release got=%b/%0d exp=%b/0", ov, State, 17'b1_0_0_0_0_0_00_10_00_10_01_0);
    end
    @(negedge clk);
    #1;
    checks++;
    if (State !== 4'd0) begin failures++; $display("FAIL midwr_hold got=%0d exp=0", State); end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_memory();
    test_branch();
    test_illegal();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
